a2d_rr_sched: RTL and testbench

- Round-robin scheduler sharing the single SPI A2D converter between the four analog inputs of the balance platform: left load cell, right load cell, steering pot and battery.
- Sequences one two-transaction SPI conversion per nxt request through the external SPI master.
- Holds the latest 12-bit result per channel.
- Feeds the sum/diff threshold logic and the steering-enable state machine.

---
 rtl/a2d_pkg.sv | 16 +
 rtl/a2d_rr_sched.sv | 123 ++++++++++++
 tb/tb_a2d_rr_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D round-robin scheduler.
package a2d_pkg;

    typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;

    localparam logic [1:0] LFT   = 2'd0;
    localparam logic [1:0] RGHT  = 2'd1;
    localparam logic [1:0] STEER = 2'd2;
    localparam logic [1:0] BATT  = 2'd3;

    // A2D command word: channel address in bits [13:11], everything else zero.
    function automatic logic [15:0] build_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_rr_sched.sv
// Round-robin scheduler for the shared SPI A2D: one two-transaction conversion per nxt.
// Optional A2D_LD_AVG_EN: 2-tap averaging on the two load-cell results.
module a2d_rr_sched
    import a2d_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        busy,
    output logic        upd,
    output logic [1:0]  upd_ch,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt
);

    state_t      state_q;
    logic [1:0]  rr_idx_q, rr_idx_d;
    logic        wrt_q, busy_q, upd_q;
    logic [1:0]  upd_ch_q;
    logic [15:0] cmd_q;
    logic [11:0] lft_q, rght_q, steer_q, batt_q;
    logic [11:0] lft_d, rght_d;
    logic [2:0]  ch_addr;

    always_comb begin
        ch_addr = CH_LFT;
        case (rr_idx_q)
            LFT:   ch_addr = CH_LFT;
            RGHT:  ch_addr = CH_RGHT;
            STEER: ch_addr = CH_STEER;
            BATT:  ch_addr = CH_BATT;
            default: ch_addr = CH_LFT;
        endcase
    end

    assign rr_idx_d = rr_idx_q + 2'd1;

`ifdef A2D_LD_AVG_EN
    logic [12:0] lft_sum, rght_sum;
    logic        unused_sum_lsb;
    assign lft_sum  = {1'b0, lft_q}  + {1'b0, rd_data[11:0]};
    assign rght_sum = {1'b0, rght_q} + {1'b0, rd_data[11:0]};
    assign lft_d    = lft_sum[12:1];
    assign rght_d   = rght_sum[12:1];
    assign unused_sum_lsb = lft_sum[0] ^ rght_sum[0];
`else
    assign lft_d  = rd_data[11:0];
    assign rght_d = rd_data[11:0];
`endif

    // Only the 12-bit conversion result is meaningful in the receive word.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_idx_q <= LFT;
            wrt_q    <= 1'b0;
            busy_q   <= 1'b0;
            upd_q    <= 1'b0;
            upd_ch_q <= 2'd0;
            cmd_q    <= 16'h0000;
            lft_q    <= 12'h000;
            rght_q   <= 12'h000;
            steer_q  <= 12'h000;
            batt_q   <= 12'h000;
        end else begin
            wrt_q <= 1'b0;
            upd_q <= 1'b0;
            case (state_q)
                IDLE: if (nxt) begin
                    wrt_q   <= 1'b1;
                    cmd_q   <= build_cmd(ch_addr);
                    busy_q  <= 1'b1;
                    state_q <= CMD;
                end
                // First transaction only selects the channel; its reply is stale.
                CMD: if (done) state_q <= GAP;
                GAP: begin
                    wrt_q   <= 1'b1;
                    state_q <= READ;
                end
                READ: if (done) begin
                    case (rr_idx_q)
                        LFT:   lft_q   <= lft_d;
                        RGHT:  rght_q  <= rght_d;
                        STEER: steer_q <= rd_data[11:0];
                        default: batt_q <= rd_data[11:0];
                    endcase
                    upd_q    <= 1'b1;
                    upd_ch_q <= rr_idx_q;
                    rr_idx_q <= rr_idx_d;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign busy      = busy_q;
    assign upd       = upd_q;
    assign upd_ch    = upd_ch_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign steer_pot = steer_q;
    assign batt      = batt_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Self-checking bench for a2d_rr_sched; the bench plays the SPI master and keeps a channel/result model.
module tb_a2d_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, busy, upd;
    logic [15:0] cmd;
    logic [1:0]  upd_ch;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    int checks = 0;
    int failures = 0;
    int wrt_cnt = 0;
    int upd_cnt = 0;

    // Reference model: channel addresses by slot, current slot, latest results.
    int m_addr [4] = '{0, 4, 5, 6};
    int m_idx = 0;
    int m_res [4] = '{0, 0, 0, 0};

    a2d_rr_sched dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done),
        .rd_data(rd_data), .busy(busy), .upd(upd), .upd_ch(upd_ch),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrt) wrt_cnt++;
        if (upd) upd_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_idx = 0;
        for (int i = 0; i < 4; i++) m_res[i] = 0;
    endtask

    task automatic model_write(input logic [11:0] nv);
`ifdef A2D_LD_AVG_EN
        if (m_idx < 2) m_res[m_idx] = (m_res[m_idx] + int'(nv)) / 2;
        else m_res[m_idx] = int'(nv);
`else
        m_res[m_idx] = int'(nv);
`endif
    endtask

    // One full conversion. inj: nxt pulses while busy (CMD, GAP, READ, and with the final done).
    // spd: spurious done during the GAP cycle.
    task automatic do_conv(input logic [15:0] data, input bit inj, input bit spd);
        int w0, u0, lat;
        logic [15:0] ecmd;
        w0 = wrt_cnt;
        u0 = upd_cnt;
        ecmd = 16'(m_addr[m_idx] * 2048);

        nxt = 1'b1; step(); nxt = 1'b0;
        checks++; if (wrt !== 1'b1) begin failures++; $display("FAIL wrt1_high got=%b exp=1", wrt); end
        checks++; if (cmd !== ecmd) begin failures++; $display("FAIL cmd got=%h exp=%h", cmd, ecmd); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_set got=%b exp=1", busy); end
        step();
        checks++; if (wrt !== 1'b0) begin failures++; $display("FAIL wrt1_width got=%b exp=0", wrt); end

        if (inj) begin nxt = 1'b1; step(); nxt = 1'b0; end
        lat = $urandom_range(0, 3);
        repeat (lat) step();
        rd_data = 16'($urandom); done = 1'b1; step(); done = 1'b0;

        // GAP cycle
        if (spd) done = 1'b1;
        if (inj) nxt = 1'b1;
        step(); done = 1'b0; nxt = 1'b0;
        checks++; if (wrt !== 1'b1) begin failures++; $display("FAIL wrt2_after_gap got=%b exp=1", wrt); end
        checks++; if (cmd !== ecmd) begin failures++; $display("FAIL cmd_hold got=%h exp=%h", cmd, ecmd); end
        step();
        checks++; if (wrt !== 1'b0) begin failures++; $display("FAIL wrt2_width got=%b exp=0", wrt); end

        if (inj) begin nxt = 1'b1; step(); nxt = 1'b0; end
        lat = $urandom_range(0, 3);
        repeat (lat) step();
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL upd_early got=%b exp=0", upd); end
        rd_data = data; done = 1'b1;
        if (inj) nxt = 1'b1;
        step(); done = 1'b0; nxt = 1'b0;

        model_write(data[11:0]);
        checks++; if (upd !== 1'b1) begin failures++; $display("FAIL upd_pulse got=%b exp=1", upd); end
        checks++; if (upd_ch !== 2'(m_idx)) begin failures++; $display("FAIL upd_ch got=%0d exp=%0d", upd_ch, m_idx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_clr got=%b exp=0", busy); end
        checks++;
        if ({lft_ld, rght_ld, steer_pot, batt} !==
            {12'(m_res[0]), 12'(m_res[1]), 12'(m_res[2]), 12'(m_res[3])}) begin
            failures++;
            $display("FAIL results got=%h/%h/%h/%h exp=%h/%h/%h/%h", lft_ld, rght_ld, steer_pot, batt,
                     12'(m_res[0]), 12'(m_res[1]), 12'(m_res[2]), 12'(m_res[3]));
        end
        m_idx = (m_idx + 1) % 4;

        step();
        checks++; if (upd !== 1'b0 || wrt !== 1'b0) begin failures++; $display("FAIL post_idle got upd=%b wrt=%b exp 0/0", upd, wrt); end
        checks++; if (wrt_cnt - w0 != 2) begin failures++; $display("FAIL wrt_count got=%0d exp=2", wrt_cnt - w0); end
        checks++; if (upd_cnt - u0 != 1) begin failures++; $display("FAIL upd_count got=%0d exp=1", upd_cnt - u0); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({wrt, busy, upd, upd_ch, cmd, lft_ld, rght_ld, steer_pot, batt} !== '0) begin
            failures++; $display("FAIL reset_state got wrt=%b busy=%b upd=%b upd_ch=%0d cmd=%h exp all 0", wrt, busy, upd, upd_ch, cmd);
        end
        rst_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_rotation();
        logic [15:0] vals [4] = '{16'h0123, 16'h0456, 16'h0789, 16'h0ABC};
        for (int i = 0; i < 4; i++) do_conv(vals[i], 1'b0, 1'b0);
`ifndef A2D_LD_AVG_EN
        checks++;
        if ({lft_ld, rght_ld, steer_pot, batt} !== {12'h123, 12'h456, 12'h789, 12'hABC}) begin
            failures++; $display("FAIL rotation got=%h/%h/%h/%h exp=123/456/789/abc", lft_ld, rght_ld, steer_pot, batt);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [11:0] r1, r2, r3;
        r1 = rght_ld; r2 = steer_pot; r3 = batt;
        do_conv(16'hF00F, 1'b0, 1'b0);
        checks++;
        if ({rght_ld, steer_pot, batt} !== {r1, r2, r3}) begin
            failures++; $display("FAIL wrap_others got=%h/%h/%h exp=%h/%h/%h", rght_ld, steer_pot, batt, r1, r2, r3);
        end
`ifndef A2D_LD_AVG_EN
        checks++; if (lft_ld !== 12'h00F) begin failures++; $display("FAIL wrap_lft got=%h exp=00f", lft_ld); end
`endif
    endtask

    task automatic test_reset_mid_read();
        nxt = 1'b1; step(); nxt = 1'b0;
        step();
        rd_data = 16'h1234; done = 1'b1; step(); done = 1'b0;
        step(); step();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({wrt, busy, upd, upd_ch, cmd, lft_ld, rght_ld, steer_pot, batt} !== '0) begin
            failures++; $display("FAIL reset_mid_read got busy=%b cmd=%h lft=%h rght=%h steer=%h batt=%h exp all 0",
                                 busy, cmd, lft_ld, rght_ld, steer_pot, batt);
        end
        rd_data = 16'h0FFF; done = 1'b1;
        step(); done = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step();
        checks++; if (upd !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_no_write got upd=%b busy=%b exp 0/0", upd, busy); end
        do_conv(16'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_busy_reject();
        do_conv(16'($urandom), 1'b1, 1'b0);
        do_conv(16'($urandom), 1'b1, 1'b0);
    endtask

    task automatic test_spurious_done();
        done = 1'b1; rd_data = 16'hBEEF; step(); done = 1'b0;
        checks++; if (busy !== 1'b0 || wrt !== 1'b0 || upd !== 1'b0) begin
            failures++; $display("FAIL idle_done got busy=%b wrt=%b upd=%b exp 0/0/0", busy, wrt, upd);
        end
        do_conv(16'($urandom), 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_conv(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

`ifdef A2D_LD_AVG_EN
    task automatic test_avg();
        test_reset();
        do_conv(16'h0800, 1'b0, 1'b0);
        checks++; if (lft_ld !== 12'h400) begin failures++; $display("FAIL avg_lft1 got=%h exp=400", lft_ld); end
        do_conv(16'h0111, 1'b0, 1'b0);
        do_conv(16'h0222, 1'b0, 1'b0);
        do_conv(16'h0FFF, 1'b0, 1'b0);
        checks++; if (batt !== 12'hFFF) begin failures++; $display("FAIL avg_batt got=%h exp=fff", batt); end
        do_conv(16'h0FFF, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_reset_mid_read();
        test_busy_reject();
        test_spurious_done();
        test_random();
`ifdef A2D_LD_AVG_EN
        test_avg();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
